// File: rtl/acc_bcd_display.sv
// -----------------------------------------------------------------------------
// acc_bcd_display
//
// Display stage for the 8-bit add/sub accumulator. A Load strobe in IDLE
// captures the signed result S and its overflow flag OF. The magnitude is
// converted to three BCD digits by a sequential shift-add-3 (double-dabble)
// engine, one bit per clock. The result drives four seven-segment digits:
// sign, hundreds, tens and ones. The displayed values hold until the next
// conversion completes.
//
// Parameters
//   SEG_ACTIVE_LOW : 1 inverts every segment bit at the output
//
// Ports
//   Clk            : rising-edge clock
//   Reset          : synchronous, active-high reset
//   Load           : capture strobe, honoured only in IDLE
//   S[7:0]         : accumulator result, signed two's complement
//   OF             : accumulator overflow flag
//   Busy           : high while a conversion is in progress
//   Done           : one-cycle pulse when new digits are valid
//   Sign           : 1 = displayed value is negative
//   Hund/Tens/Ones : BCD digits of |S|
//   OvfOut         : OF captured together with the displayed value
//   Seg3..Seg0     : segments {g,f,e,d,c,b,a}; Seg3 = sign, Seg0 = ones
// -----------------------------------------------------------------------------
module acc_bcd_display #(
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Load,
    input  logic [7:0] S,
    input  logic       OF,
    output logic       Busy,
    output logic       Done,
    output logic       Sign,
    output logic [3:0] Hund,
    output logic [3:0] Tens,
    output logic [3:0] Ones,
    output logic       OvfOut,
    output logic [6:0] Seg3,
    output logic [6:0] Seg2,
    output logic [6:0] Seg1,
    output logic [6:0] Seg0
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    state_t      state_reg;
    logic [7:0]  mag_reg;        // magnitude being shifted out MSB first
    logic [11:0] scratch_reg;    // BCD accumulator {hund, tens, ones}
    logic [2:0]  cnt_reg;        // iteration counter, 0..7
    logic        pend_sign_reg;
    logic        pend_ovf_reg;

    logic        busy_reg;
    logic        done_reg;
    logic        sign_reg;
    logic        ovf_reg;
    logic [3:0]  hund_reg;
    logic [3:0]  tens_reg;
    logic [3:0]  ones_reg;

    logic [7:0]  mag_capture;
    logic [11:0] scratch_adj;
    logic [11:0] scratch_next;

    // Two's complement magnitude; 8'h80 naturally maps to 128.
    assign mag_capture = S[7] ? (~S + 8'd1) : S;

    // Add-3 correction on every BCD nibble that would overflow past 9
    // once doubled by the following shift.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_adj
            assign scratch_adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5)
                                          ? scratch_reg[gi*4 +: 4] + 4'd3
                                          : scratch_reg[gi*4 +: 4];
        end
    endgenerate

    assign scratch_next = {scratch_adj[10:0], mag_reg[7]};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg     <= ST_IDLE;
            mag_reg       <= 8'd0;
            scratch_reg   <= 12'd0;
            cnt_reg       <= 3'd0;
            pend_sign_reg <= 1'b0;
            pend_ovf_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            sign_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            hund_reg      <= 4'd0;
            tens_reg      <= 4'd0;
            ones_reg      <= 4'd0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (Load) begin
                        mag_reg       <= mag_capture;
                        // A zero magnitude is always shown as positive.
                        pend_sign_reg <= S[7] & (mag_capture != 8'd0);
                        pend_ovf_reg  <= OF;
                        scratch_reg   <= 12'd0;
                        cnt_reg       <= 3'd0;
                        busy_reg      <= 1'b1;
                        state_reg     <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    scratch_reg <= scratch_next;
                    mag_reg     <= {mag_reg[6:0], 1'b0};
                    cnt_reg     <= cnt_reg + 3'd1;
                    if (cnt_reg == 3'd7) begin
                        // Last shift: publish the post-shift digits directly.
                        hund_reg  <= scratch_next[11:8];
                        tens_reg  <= scratch_next[7:4];
                        ones_reg  <= scratch_next[3:0];
                        sign_reg  <= pend_sign_reg;
                        ovf_reg   <= pend_ovf_reg;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy   = busy_reg;
    assign Done   = done_reg;
    assign Sign   = sign_reg;
    assign OvfOut = ovf_reg;
    assign Hund   = hund_reg;
    assign Tens   = tens_reg;
    assign Ones   = ones_reg;

    // Seven-segment decode, active-high {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'h3F;
            4'd1:    code = 7'h06;
            4'd2:    code = 7'h5B;
            4'd3:    code = 7'h4F;
            4'd4:    code = 7'h66;
            4'd5:    code = 7'h6D;
            4'd6:    code = 7'h7D;
            4'd7:    code = 7'h07;
            4'd8:    code = 7'h7F;
            4'd9:    code = 7'h6F;
            default: code = 7'h00;
        endcase
        return code;
    endfunction

    logic [6:0] seg_raw [4];
    logic [6:0] seg_out [4];

    // Leading-zero blanking: tens blanks only when hundreds is also zero.
    always_comb begin
        seg_raw[0] = seg_decode(ones_reg);
        seg_raw[1] = ((hund_reg == 4'd0) && (tens_reg == 4'd0)) ? 7'h00
                                                                 : seg_decode(tens_reg);
        seg_raw[2] = (hund_reg == 4'd0) ? 7'h00 : seg_decode(hund_reg);
        seg_raw[3] = sign_reg ? 7'h40 : 7'h00;
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pol
            assign seg_out[gi] = seg_raw[gi] ^ {7{SEG_ACTIVE_LOW}};
        end
    endgenerate

    assign Seg0 = seg_out[0];
    assign Seg1 = seg_out[1];
    assign Seg2 = seg_out[2];
    assign Seg3 = seg_out[3];

endmodule

// File: tb/tb_acc_bcd_display.sv
// -----------------------------------------------------------------------------
// tb_acc_bcd_display
//
// Scoreboard bench: each accepted capture pushes its hand-computed expected
// digits into a queue; a monitor pops and compares every time Done pulses.
// Driver changes inputs on the falling edge; monitor samples 2 ns after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_acc_bcd_display;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Load = 1'b0;
    logic [7:0] S = 8'd0;
    logic       OF = 1'b0;
    logic       Busy, Done, Sign, OvfOut;
    logic [3:0] Hund, Tens, Ones;
    logic [6:0] Seg3, Seg2, Seg1, Seg0;

    acc_bcd_display #(.SEG_ACTIVE_LOW(1'b0)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Load   (Load),
        .S      (S),
        .OF     (OF),
        .Busy   (Busy),
        .Done   (Done),
        .Sign   (Sign),
        .Hund   (Hund),
        .Tens   (Tens),
        .Ones   (Ones),
        .OvfOut (OvfOut),
        .Seg3   (Seg3),
        .Seg2   (Seg2),
        .Seg1   (Seg1),
        .Seg0   (Seg0)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int h;
        int t;
        int o;
        int sgn;
        int ovf;
    } exp_t;

    exp_t exp_q[$];
    int   done_cycles[$];
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;
    int   done_count = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic int seg_of(input int d);
        case (d)
            0: return 'h3F;
            1: return 'h06;
            2: return 'h5B;
            3: return 'h4F;
            4: return 'h66;
            5: return 'h6D;
            6: return 'h7D;
            7: return 'h07;
            8: return 'h7F;
            9: return 'h6F;
            default: return 'h00;
        endcase
    endfunction

    // Monitor: compare every Done pulse against the oldest expectation.
    initial begin
        forever begin
            @(posedge Clk);
            cycle++;
            #2;
            if (Done) begin
                exp_t e;
                done_count++;
                done_cycles.push_back(cycle);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done: got Done=1 with digits %0d/%0d/%0d expected no Done",
                             Hund, Tens, Ones);
                end else begin
                    e = exp_q.pop_front();
                    $display("done: digits=%0d/%0d/%0d sign=%0d ovf=%0d seg=%h/%h/%h/%h",
                             Hund, Tens, Ones, Sign, OvfOut, Seg3, Seg2, Seg1, Seg0);
                    check("hund", int'(Hund), e.h);
                    check("tens", int'(Tens), e.t);
                    check("ones", int'(Ones), e.o);
                    check("sign", int'(Sign), e.sgn);
                    check("ovf", int'(OvfOut), e.ovf);
                    check("seg0", int'(Seg0), seg_of(e.o));
                    check("seg1", int'(Seg1), (e.h == 0 && e.t == 0) ? 0 : seg_of(e.t));
                    check("seg2", int'(Seg2), (e.h == 0) ? 0 : seg_of(e.h));
                    check("seg3", int'(Seg3), e.sgn ? 'h40 : 'h00);
                end
            end
        end
    end

    task automatic push_exp(input int h, input int t, input int o, input int sgn, input int ovf);
        exp_t e;
        e.h = h; e.t = t; e.o = o; e.sgn = sgn; e.ovf = ovf;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        $display("reset state check (%s)", tag);
        check({tag, "_hund"}, int'(Hund), 0);
        check({tag, "_tens"}, int'(Tens), 0);
        check({tag, "_ones"}, int'(Ones), 0);
        check({tag, "_sign"}, int'(Sign), 0);
        check({tag, "_ovf"}, int'(OvfOut), 0);
        check({tag, "_busy"}, int'(Busy), 0);
        check({tag, "_done"}, int'(Done), 0);
        check({tag, "_seg0"}, int'(Seg0), 'h3F);
        check({tag, "_seg1"}, int'(Seg1), 0);
        check({tag, "_seg2"}, int'(Seg2), 0);
        check({tag, "_seg3"}, int'(Seg3), 0);
    endtask

    // One full conversion with Busy/Done timing and output stability checks.
    task automatic conv(input logic [7:0] s, input logic of_in,
                        input int h, input int t, input int o, input int sgn, input int ovf);
        int busy_n;
        int stable;
        logic [3:0] h0, t0, o0;
        @(negedge Clk);
        h0 = Hund; t0 = Tens; o0 = Ones;
        Load = 1'b1; S = s; OF = of_in;
        push_exp(h, t, o, sgn, ovf);
        $display("load: S=0x%02h OF=%0d", s, of_in);
        busy_n = 0;
        stable = 1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge Clk);
            Load = 1'b0;
            if (k <= 8) begin
                if (Busy) busy_n++;
                if (Done || Hund != h0 || Tens != t0 || Ones != o0) stable = 0;
            end else begin
                check("done_at_e8", int'(Done), 1);
                check("busy_clear_e8", int'(Busy), 0);
            end
        end
        check("busy_cycles", busy_n, 8);
        check("stable_during_conv", stable, 1);
    endtask

    initial begin
        int n0;
        int sz;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (5) @(negedge Clk);
        check_reset_state("idle");

        conv(8'd123, 1'b0, 1, 2, 3, 0, 0);
        conv(8'h80,  1'b1, 1, 2, 8, 1, 1);
        conv(8'hF9,  1'b0, 0, 0, 7, 1, 0);
        conv(8'd0,   1'b0, 0, 0, 0, 0, 0);

        // Load during CONV must be ignored.
        n0 = done_count;
        @(negedge Clk);
        Load = 1'b1; S = 8'd45; OF = 1'b0;
        push_exp(0, 4, 5, 0, 0);
        $display("load: S=0x%02h OF=0 (then ignored load S=0x63)", 8'd45);
        @(negedge Clk); Load = 1'b0;
        @(negedge Clk);
        @(negedge Clk); Load = 1'b1; S = 8'd99;
        @(negedge Clk); Load = 1'b0; S = 8'd0;
        repeat (20) @(negedge Clk);
        check("ignored_load_done_count", done_count - n0, 1);

        // Load held high: a capture every 9 cycles.
        n0 = done_count;
        @(negedge Clk);
        Load = 1'b1; S = 8'd37; OF = 1'b0;
        push_exp(0, 3, 7, 0, 0);
        push_exp(0, 3, 7, 0, 0);
        push_exp(0, 3, 7, 0, 0);
        $display("load held: S=0x%02h for three captures", 8'd37);
        repeat (19) @(negedge Clk);
        Load = 1'b0;
        repeat (12) @(negedge Clk);
        check("held_load_done_count", done_count - n0, 3);
        sz = done_cycles.size();
        if (sz >= 3) begin
            check("done_period_a", done_cycles[sz-2] - done_cycles[sz-3], 9);
            check("done_period_b", done_cycles[sz-1] - done_cycles[sz-2], 9);
        end else begin
            check("done_history", sz, 3);
        end

        // Reset mid-conversion: no Done, outputs back to reset values.
        n0 = done_count;
        @(negedge Clk);
        Load = 1'b1; S = 8'd77; OF = 1'b1;
        $display("load: S=0x%02h OF=1 (aborted by reset)", 8'd77);
        @(negedge Clk); Load = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check_reset_state("abort");
        repeat (12) @(negedge Clk);
        check("abort_no_done", done_count - n0, 0);

        conv(8'd77, 1'b0, 0, 7, 7, 0, 0);

        repeat (3) @(negedge Clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
